alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Parametrised out-of-order issue queue for the integer ALU cluster, placed between the instruction dispatcher and the common data bus (CDB). It accepts up to DISPATCH_WIDTH renamed ALU ops per cycle, wakes operands from CDB broadcasts, issues up to ISSUE_WIDTH ready ops per cycle oldest-first into internal single-cycle alu32 lanes, and holds each result in a registered output lane until the CDB accepts it. Unlike the previous station, it has age-ordered select, CDB back-pressure, same-cycle dispatch capture, and flush.

## Interface
- DEPTH, 16: entry count, power of two, 4..64
- DISPATCH_WIDTH, 2: dispatch lanes, 1..4
- ISSUE_WIDTH, 2: ALU lanes / output lanes, 1..4
- CDB_PORTS, 2: external wakeup broadcast ports
- ROB_ID_WIDTH, 5: tag width; tags are compared on rs*_data[ROB_ID_WIDTH-1:0]
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- flush  in  1  synchronous squash of all contents
- dispatch_valid  in  [DISPATCH_WIDTH]  per-lane request
- dispatch_data  in  rs_entry_t[DISPATCH_WIDTH]  renamed op
- dispatch_ready  out  1  all lanes may dispatch this cycle
- free_count  out  $clog2(DEPTH+1)  vacant entries, registered state
- broadcast  in  cdb_entry_t[CDB_PORTS]  external wakeups
- result  out  cdb_entry_t[ISSUE_WIDTH]  output lanes (valid, rob_id, rd_v)
- result_ready  in  [ISSUE_WIDTH]  CDB accepts lane this cycle

## Operation
- Entry: rs_entry_t plus an age rank. Ready = valid & ~rs1_renamed & ~rs2_renamed.
- Dispatch: dispatch_ready = (free_count >= DISPATCH_WIDTH). Lane k is written when dispatch_valid[k] & dispatch_ready, into the k-th lowest-index vacant slot. Lane order defines age: lane 0 is older than lane 1 in the same cycle; all same-cycle dispatches are younger than every resident entry.
- Wakeup sources: every broadcast[j] with valid, plus every result[l] firing (valid & result_ready). On a tag match against a renamed operand, data <= rd_v and renamed <= 0. Multiple matches carry identical data; the lowest-index source wins.
- Dispatch capture: an op dispatched in the same cycle as a matching wakeup is written with the operand already resolved.
- Select: each cycle a lane is free when result[l].valid = 0 or result_ready[l] = 1. Up to (number of free lanes) ready entries are chosen, oldest first. The oldest goes to the lowest-index free lane. Chosen entries drive alu32 (rs1_data, rs2_data, funct3, funct7). At the edge, the output lane loads {1, rob_id, alu_out} and the entry is vacated.
- Entries are never issued from a stalled lane. A lane holds its result unchanged while valid & ~result_ready.
- Flush or rst: all entries invalid, all result lanes cleared, and dispatch/wakeup ignored that cycle. Flush has priority over every other event.
- A vacated slot may be reused by dispatch on the next cycle. free_count never counts same-cycle issues.

## Timing
- Reset values: result[*] = '0, dispatch_ready = 1 (DISPATCH_WIDTH <= DEPTH), free_count = DEPTH.
- Dispatch at edge t: the entry is eligible for select at cycle t (post-edge). The earliest result is valid after edge t+1, i.e. 1 cycle of queue latency.
- Wakeup in cycle t: the consumer is selectable in cycle t+1. Back-to-back dependent issue through own-lane firing therefore costs 1 bubble.
- Full: free_count < DISPATCH_WIDTH deasserts dispatch_ready, even if issues free slots that cycle.
- All outputs are registered state or simple functions of it. There is no combinational path from result_ready to dispatch_ready.

## Test plan
- Reset then single dispatch: ADD rs1 = 5, rs2 = 7, rob_id = 3. Result lane 0 goes valid {rob_id 3, rd_v 12} two cycles after dispatch; free_count returns to 16.
- Wakeup: dispatch SUB with rs1 renamed tag 9, rs2 = 1, then broadcast {valid, rob_id 9, rd_v 10}. The op issues the next cycle with result rd_v = 9. An unrelated tag 8 must not wake it.
- Age order: fill 3 ready ops over 3 cycles while result_ready = 0 on both lanes. When readiness returns, the oldest two issue first, in lanes 0 and 1, and the youngest issues next cycle.
- Back-pressure: hold result_ready[0] = 0 for 5 cycles. Lane 0 data is stable throughout, nothing else issues into lane 0, and lane 1 continues issuing.
- Full/flush: dispatch to 15 entries. dispatch_ready drops at 15 (width 2). Then assert flush alongside dispatch_valid: free_count = 16, all result lanes invalid, and the flushed-cycle dispatch is discarded.
- Same-cycle capture: dispatch an op whose rs2 tag 4 is broadcast in the same cycle with rd_v = 0xFFFF_FFFF. It issues the following cycle using 0xFFFF_FFFF.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Out-of-order issue queue for the integer ALU cluster: CDB wakeup, oldest-first select into
// single-cycle ALU lanes, registered result lanes held under CDB back-pressure, and flush.
module alu_issue_queue #(
    parameter int DEPTH          = 16,
    parameter int DISPATCH_WIDTH = 2,
    parameter int ISSUE_WIDTH    = 2,
    parameter int CDB_PORTS      = 2,
    parameter int ROB_ID_WIDTH   = 5,
    localparam int RS_W          = ROB_ID_WIDTH + 76,
    localparam int CDB_W         = ROB_ID_WIDTH + 33,
    localparam int FC_W          = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [DISPATCH_WIDTH-1:0]      dispatch_valid,
    input  logic [DISPATCH_WIDTH*RS_W-1:0] dispatch_data,
    output logic                           dispatch_ready,
    output logic [FC_W-1:0]                free_count,
    input  logic [CDB_PORTS*CDB_W-1:0]     broadcast,
    output logic [ISSUE_WIDTH*CDB_W-1:0]   result,
    input  logic [ISSUE_WIDTH-1:0]         result_ready
);

    // Lane k of a flattened bus occupies bits [k*W +: W], packed as the structs below (MSB first).
    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic [6:0]              funct7;
        logic [2:0]              funct3;
        logic                    rs1_renamed;
        logic [31:0]             rs1_data;
        logic                    rs2_renamed;
        logic [31:0]             rs2_data;
    } rs_entry_t;

    typedef struct packed {
        logic                    valid;
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic [31:0]             rd_v;
    } cdb_entry_t;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SRC_N = CDB_PORTS + ISSUE_WIDTH;

    logic [DEPTH-1:0]          ent_valid;
    rs_entry_t                 ent [DEPTH];
    logic [DEPTH-1:0]          older [DEPTH];
    cdb_entry_t                res [ISSUE_WIDTH];
    logic [FC_W-1:0]           free_cnt;

    logic [ISSUE_WIDTH*CDB_W-1:0] fire_flat;
    logic [SRC_N*CDB_W-1:0]       src_flat;
    rs_entry_t                 ent_wk [DEPTH];
    rs_entry_t                 disp_in [DISPATCH_WIDTH];
    rs_entry_t                 disp_wk [DISPATCH_WIDTH];
    logic [DEPTH-1:0]          ready;
    logic [FC_W-1:0]           pos [DEPTH];
    logic [ISSUE_WIDTH-1:0]    lane_free;
    logic [FC_W-1:0]           lane_rank [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]    sel_valid;
    logic [IDX_W-1:0]          sel_idx [ISSUE_WIDTH];
    logic [31:0]               alu_out [ISSUE_WIDTH];
    logic [DEPTH-1:0]          issue;
    logic [FC_W-1:0]           n_issue;
    logic [DISPATCH_WIDTH-1:0] do_disp;
    logic [IDX_W-1:0]          slot [DISPATCH_WIDTH];
    logic [DEPTH-1:0]          is_new;
    logic [2:0]                new_lane [DEPTH];
    logic [FC_W-1:0]           n_disp;

    function automatic logic [31:0] alu32(input logic [2:0] funct3, input logic [6:0] funct7,
                                          input logic [31:0] a, input logic [31:0] b);
        logic        alt;
        logic [31:0] r;
        alt = (funct7 == 7'b0100000);
        case (funct3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Sources are scanned high to low so the lowest-index match is the one that sticks.
    function automatic rs_entry_t wake(input rs_entry_t e, input logic [SRC_N*CDB_W-1:0] s_flat);
        cdb_entry_t s;
        rs_entry_t  w;
        w = e;
        for (int j = SRC_N - 1; j >= 0; j--) begin
            s = s_flat[j*CDB_W +: CDB_W];
            if (s.valid && e.rs1_renamed && e.rs1_data[ROB_ID_WIDTH-1:0] == s.rob_id) begin
                w.rs1_renamed = 1'b0;
                w.rs1_data    = s.rd_v;
            end
            if (s.valid && e.rs2_renamed && e.rs2_data[ROB_ID_WIDTH-1:0] == s.rob_id) begin
                w.rs2_renamed = 1'b0;
                w.rs2_data    = s.rd_v;
            end
        end
        return w;
    endfunction

    always_comb begin
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            result[l*CDB_W +: CDB_W]    = res[l];
            fire_flat[l*CDB_W +: CDB_W] = {res[l].valid & result_ready[l], res[l].rob_id, res[l].rd_v};
        end
    end

    assign src_flat       = {fire_flat, broadcast};
    assign free_count     = free_cnt;
    assign dispatch_ready = (free_cnt >= FC_W'(DISPATCH_WIDTH));

    // pos[i] = number of ready entries older than i, i.e. its rank in oldest-first order.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i]  = ent_valid[i] & ~ent[i].rs1_renamed & ~ent[i].rs2_renamed;
            ent_wk[i] = wake(ent[i], src_flat);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pos[i] = '0;
            for (int j = 0; j < DEPTH; j++)
                if (ready[j] && older[j][i]) pos[i] = pos[i] + 1'b1;
        end
    end

    always_comb begin
        issue   = '0;
        n_issue = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            lane_free[l] = ~res[l].valid | result_ready[l];
            lane_rank[l] = '0;
            for (int m = 0; m < l; m++)
                if (~res[m].valid | result_ready[m]) lane_rank[l] = lane_rank[l] + 1'b1;
            sel_valid[l] = 1'b0;
            sel_idx[l]   = '0;
            if (lane_free[l]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ready[i] && pos[i] == lane_rank[l]) begin
                        sel_valid[l] = 1'b1;
                        sel_idx[l]   = IDX_W'(i);
                    end
                end
            end
            if (sel_valid[l]) begin
                issue[sel_idx[l]] = 1'b1;
                n_issue           = n_issue + 1'b1;
            end
            alu_out[l] = alu32(ent[sel_idx[l]].funct3, ent[sel_idx[l]].funct7,
                               ent[sel_idx[l]].rs1_data, ent[sel_idx[l]].rs2_data);
        end
    end

    always_comb begin
        int cnt;
        cnt    = 0;
        n_disp = '0;
        is_new = '0;
        for (int i = 0; i < DEPTH; i++) new_lane[i] = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            disp_in[k] = dispatch_data[k*RS_W +: RS_W];
            disp_wk[k] = wake(disp_in[k], src_flat);
            do_disp[k] = dispatch_valid[k] & dispatch_ready;
            slot[k]    = '0;
            if (do_disp[k]) n_disp = n_disp + 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_valid[i]) begin
                for (int k = 0; k < DISPATCH_WIDTH; k++)
                    if (cnt == k) slot[k] = IDX_W'(i);
                cnt = cnt + 1;
            end
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (do_disp[k]) begin
                is_new[slot[k]]   = 1'b1;
                new_lane[slot[k]] = 3'(k);
            end
        end
    end

    // New entries are younger than every resident; among themselves, lower lane is older.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_valid <= '0;
            free_cnt  <= FC_W'(DEPTH);
            for (int l = 0; l < ISSUE_WIDTH; l++) res[l] <= '0;
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i]) ent[i] <= ent_wk[i];
                if (issue[i]) ent_valid[i] <= 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (is_new[i] && is_new[j]) older[i][j] <= (new_lane[i] < new_lane[j]);
                    else if (is_new[i])         older[i][j] <= 1'b0;
                    else if (is_new[j])         older[i][j] <= 1'b1;
                end
            end
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (do_disp[k]) begin
                    ent_valid[slot[k]] <= 1'b1;
                    ent[slot[k]]       <= disp_wk[k];
                end
            end
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (sel_valid[l])      res[l] <= {1'b1, ent[sel_idx[l]].rob_id, alu_out[l]};
                else if (lane_free[l]) res[l] <= '0;
            end
            free_cnt <= free_cnt - n_disp + n_issue;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (default parameters): reset, wakeup, age order,
// back-pressure, dependent chain, same-cycle capture, full and flush.
module tb_alu_issue_queue;
    localparam int RS_W  = 81;
    localparam int CDB_W = 38;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [1:0]   dispatch_valid;
    logic [161:0] dispatch_data;
    logic         dispatch_ready;
    logic [4:0]   free_count;
    logic [75:0]  broadcast;
    logic [75:0]  result;
    logic [1:0]   result_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_queue dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_data  (dispatch_data),
        .dispatch_ready (dispatch_ready),
        .free_count     (free_count),
        .broadcast      (broadcast),
        .result         (result),
        .result_ready   (result_ready)
    );

    function automatic logic [80:0] op(input logic [4:0] rob, input logic [2:0] f3, input logic alt,
                                       input logic r1n, input logic [31:0] r1,
                                       input logic r2n, input logic [31:0] r2);
        logic [6:0] f7;
        f7 = alt ? 7'h20 : 7'h00;
        return {rob, f7, f3, r1n, r1, r2n, r2};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input int l, input logic v,
                              input logic [4:0] rob, input logic [31:0] rd);
        logic [37:0] lane;
        lane = result[l*CDB_W +: CDB_W];
        if (v) check(tag, 128'(lane), 128'({v, rob, rd}));
        else   check(tag, 128'(lane[37]), 128'(1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = '0;
        dispatch_data  = '0;
        broadcast      = '0;
    endtask

    task automatic set_disp(input int lane, input logic [80:0] d);
        dispatch_valid[lane]             = 1'b1;
        dispatch_data[lane*RS_W +: RS_W] = d;
    endtask

    task automatic bc(input int port, input logic [4:0] rob, input logic [31:0] rd);
        broadcast[port*CDB_W +: CDB_W] = {1'b1, rob, rd};
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        result_ready = 2'b11;
        idle();
        tick();
        tick();
        check("reset_result", 128'(result), 128'(0));
        check("reset_dispatch_ready", 128'(dispatch_ready), 128'(1));
        check("reset_free_count", 128'(free_count), 128'(16));
        rst = 1'b0;

        // single ADD 5 + 7
        set_disp(0, op(5'd3, 3'd0, 1'b0, 1'b0, 32'd5, 1'b0, 32'd7));
        tick();
        check("add_free_after_dispatch", 128'(free_count), 128'(15));
        idle();
        tick();
        check_lane("add_lane0", 0, 1'b1, 5'd3, 32'd12);
        check_lane("add_lane1_idle", 1, 1'b0, 5'd0, 32'd0);
        check("add_free_restored", 128'(free_count), 128'(16));
        tick();
        check_lane("add_lane0_drained", 0, 1'b0, 5'd0, 32'd0);

        // SUB waiting on tag 9; tag 8 must not wake it
        set_disp(0, op(5'd1, 3'd0, 1'b1, 1'b1, 32'd9, 1'b0, 32'd1));
        tick();
        idle();
        bc(0, 5'd8, 32'd100);
        tick();
        check("wake_free_waiting", 128'(free_count), 128'(15));
        idle();
        bc(1, 5'd9, 32'd10);
        tick();
        check_lane("wake_no_issue_on_tag8", 0, 1'b0, 5'd0, 32'd0);
        idle();
        tick();
        check_lane("wake_sub_result", 0, 1'b1, 5'd1, 32'd9);
        tick();
        check("wake_free_restored", 128'(free_count), 128'(16));

        // age order under stalled lanes
        result_ready = 2'b00;
        set_disp(0, op(5'd20, 3'd0, 1'b0, 1'b0, 32'd1, 1'b0, 32'd1));
        set_disp(1, op(5'd21, 3'd0, 1'b0, 1'b0, 32'd2, 1'b0, 32'd2));
        tick();
        idle();
        set_disp(0, op(5'd10, 3'd4, 1'b0, 1'b0, 32'hF0, 1'b0, 32'hFF));
        tick();
        check_lane("age_filler_lane0", 0, 1'b1, 5'd20, 32'd2);
        check_lane("age_filler_lane1", 1, 1'b1, 5'd21, 32'd4);
        idle();
        set_disp(0, op(5'd11, 3'd6, 1'b0, 1'b0, 32'h10, 1'b0, 32'h01));
        tick();
        idle();
        set_disp(0, op(5'd12, 3'd7, 1'b0, 1'b0, 32'hFF, 1'b0, 32'h3C));
        tick();
        idle();
        check("age_free_three_waiting", 128'(free_count), 128'(13));
        check_lane("age_filler_held", 0, 1'b1, 5'd20, 32'd2);
        result_ready = 2'b11;
        tick();
        check_lane("age_oldest_lane0", 0, 1'b1, 5'd10, 32'h0F);
        check_lane("age_second_lane1", 1, 1'b1, 5'd11, 32'h11);
        tick();
        check_lane("age_youngest_lane0", 0, 1'b1, 5'd12, 32'h3C);
        check_lane("age_lane1_empty", 1, 1'b0, 5'd0, 32'd0);
        tick();
        check("age_free_restored", 128'(free_count), 128'(16));

        // back-pressure on lane 0, lane 1 keeps issuing
        result_ready = 2'b10;
        set_disp(0, op(5'd5, 3'd0, 1'b0, 1'b0, 32'd100, 1'b0, 32'd1));
        tick();
        idle();
        set_disp(0, op(5'd6, 3'd0, 1'b0, 1'b0, 32'd3, 1'b0, 32'd3));
        tick();
        check_lane("bp_stall_c1_lane0", 0, 1'b1, 5'd5, 32'd101);
        idle();
        set_disp(0, op(5'd7, 3'd0, 1'b1, 1'b0, 32'd10, 1'b0, 32'd3));
        tick();
        check_lane("bp_stall_c2_lane0", 0, 1'b1, 5'd5, 32'd101);
        check_lane("bp_lane1_first", 1, 1'b1, 5'd6, 32'd6);
        idle();
        tick();
        check_lane("bp_stall_c3_lane0", 0, 1'b1, 5'd5, 32'd101);
        check_lane("bp_lane1_second", 1, 1'b1, 5'd7, 32'd7);
        tick();
        check_lane("bp_stall_c4_lane0", 0, 1'b1, 5'd5, 32'd101);
        check_lane("bp_lane1_drained", 1, 1'b0, 5'd0, 32'd0);
        tick();
        check_lane("bp_stall_c5_lane0", 0, 1'b1, 5'd5, 32'd101);
        result_ready = 2'b11;
        tick();
        check_lane("bp_lane0_released", 0, 1'b0, 5'd0, 32'd0);
        check("bp_free_restored", 128'(free_count), 128'(16));

        // dependent pair woken by own-lane firing: one bubble
        set_disp(0, op(5'd12, 3'd0, 1'b0, 1'b0, 32'd2, 1'b0, 32'd3));
        set_disp(1, op(5'd13, 3'd0, 1'b0, 1'b1, 32'd12, 1'b0, 32'd10));
        tick();
        idle();
        tick();
        check_lane("chain_producer", 0, 1'b1, 5'd12, 32'd5);
        check_lane("chain_consumer_not_yet", 1, 1'b0, 5'd0, 32'd0);
        tick();
        check_lane("chain_bubble", 0, 1'b0, 5'd0, 32'd0);
        tick();
        check_lane("chain_consumer", 0, 1'b1, 5'd13, 32'd15);
        tick();

        // same-cycle dispatch capture of a broadcast operand
        set_disp(0, op(5'd2, 3'd6, 1'b0, 1'b0, 32'd0, 1'b1, 32'd4));
        bc(0, 5'd4, 32'hFFFF_FFFF);
        tick();
        idle();
        tick();
        check_lane("capture_result", 0, 1'b1, 5'd2, 32'hFFFF_FFFF);
        tick();

        // fill to 15 entries, then flush with dispatch asserted
        result_ready = 2'b00;
        for (int c = 0; c < 7; c++) begin
            set_disp(0, op(5'd30, 3'd0, 1'b0, 1'b1, 32'd30, 1'b0, 32'd0));
            set_disp(1, op(5'd30, 3'd0, 1'b0, 1'b1, 32'd30, 1'b0, 32'd0));
            tick();
            check("fill_free_count", 128'(free_count), 128'(16 - 2 * (c + 1)));
            check("fill_ready", 128'(dispatch_ready), 128'((16 - 2 * (c + 1)) >= 2));
        end
        idle();
        set_disp(0, op(5'd30, 3'd0, 1'b0, 1'b1, 32'd30, 1'b0, 32'd0));
        tick();
        check("full_free_count", 128'(free_count), 128'(1));
        check("full_ready_low", 128'(dispatch_ready), 128'(0));
        set_disp(0, op(5'd30, 3'd0, 1'b0, 1'b1, 32'd30, 1'b0, 32'd0));
        set_disp(1, op(5'd30, 3'd0, 1'b0, 1'b1, 32'd30, 1'b0, 32'd0));
        tick();
        check("full_dispatch_blocked", 128'(free_count), 128'(1));
        flush = 1'b1;
        tick();
        check("flush_free_count", 128'(free_count), 128'(16));
        check_lane("flush_lane0", 0, 1'b0, 5'd0, 32'd0);
        check_lane("flush_lane1", 1, 1'b0, 5'd0, 32'd0);
        check("flush_ready", 128'(dispatch_ready), 128'(1));
        flush = 1'b0;
        idle();
        tick();
        check("flush_dispatch_discarded", 128'(free_count), 128'(16));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
